// File: rtl/uart_core.sv
// uart_core: single-clock 8N1 UART (transmitter + receiver) with an
// internal per-path bit-period counter. The counters produce clock enables
// only. No derived clocks are used.
//
// Parameters:
//   CLKS_PER_BIT    system clocks per bit period (4..65535)
//
// Ports:
//   clock           system clock, all logic on the rising edge
//   reset_n         asynchronous active-low reset
//   tx_data         byte to transmit, latched when a frame starts
//   tx_enable       transmit request (level, sampled in IDLE)
//   tx_serial       serial line out, idles high
//   tx_done         one-cycle pulse at the end of the stop bit
//   tx_busy         high while a frame is in progress
//   tx_state        transmitter state code (IDLE=0 .. CLEANUP=4)
//   tx_byte_index   index of the data bit currently being sent
//   rx_serial       serial line in (asynchronous to clock)
//   rx_data         last correctly framed byte
//   rx_valid        one-cycle pulse when rx_data updates
//   rx_frame_error  one-cycle pulse when the stop bit samples low
module uart_core #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_enable,
    output logic       tx_serial,
    output logic       tx_done,
    output logic       tx_busy,
    output logic [2:0] tx_state,
    output logic [2:0] tx_byte_index,
    input  logic       rx_serial,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_error
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);

    // Last clock of a bit period, and the clock that lands on mid-bit
    // measured from the detected start edge.
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_MID  = CW'((CLKS_PER_BIT - 1) / 2);

    localparam logic [2:0] TX_IDLE    = 3'd0;
    localparam logic [2:0] TX_START   = 3'd1;
    localparam logic [2:0] TX_DATA    = 3'd2;
    localparam logic [2:0] TX_STOP    = 3'd3;
    localparam logic [2:0] TX_CLEANUP = 3'd4;

    localparam logic [2:0] RX_IDLE    = 3'd0;
    localparam logic [2:0] RX_START   = 3'd1;
    localparam logic [2:0] RX_DATA    = 3'd2;
    localparam logic [2:0] RX_STOP    = 3'd3;
    localparam logic [2:0] RX_CLEANUP = 3'd4;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    logic [2:0]    tx_state_q,  tx_state_d;
    logic [CW-1:0] tx_cnt_q,    tx_cnt_d;
    logic [2:0]    tx_idx_q,    tx_idx_d;
    logic [7:0]    tx_shift_q,  tx_shift_d;
    logic          tx_serial_q, tx_serial_d;
    logic          tx_done_q,   tx_done_d;
    logic          tx_busy_q,   tx_busy_d;

    // tx_serial is registered and updated on the same edge as the state,
    // so the line level always matches the bit the FSM is timing. The
    // shift register is shifted right per bit, keeping the current bit
    // in tx_shift_q[0].
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_idx_d    = tx_idx_q;
        tx_shift_d  = tx_shift_q;
        tx_serial_d = tx_serial_q;
        tx_busy_d   = tx_busy_q;
        tx_done_d   = 1'b0;

        case (tx_state_q)
            TX_IDLE: begin
                tx_serial_d = 1'b1;
                tx_cnt_d    = '0;
                tx_idx_d    = '0;
                if (tx_enable) begin
                    tx_shift_d  = tx_data;
                    tx_busy_d   = 1'b1;
                    tx_serial_d = 1'b0;
                    tx_state_d  = TX_START;
                end
            end

            TX_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d    = '0;
                    tx_serial_d = tx_shift_q[0];
                    tx_state_d  = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end

            TX_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    if (tx_idx_q == 3'd7) begin
                        tx_idx_d    = '0;
                        tx_serial_d = 1'b1;
                        tx_state_d  = TX_STOP;
                    end else begin
                        tx_idx_d    = tx_idx_q + 3'd1;
                        tx_serial_d = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end

            TX_STOP: begin
                tx_serial_d = 1'b1;
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_done_d  = 1'b1;
                    tx_state_d = TX_CLEANUP;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end

            TX_CLEANUP: begin
                tx_serial_d = 1'b1;
                tx_busy_d   = 1'b0;
                tx_state_d  = TX_IDLE;
            end

            default: begin
                tx_serial_d = 1'b1;
                tx_busy_d   = 1'b0;
                tx_cnt_d    = '0;
                tx_idx_d    = '0;
                tx_state_d  = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= '0;
            tx_idx_q    <= '0;
            tx_shift_q  <= '0;
            tx_serial_q <= 1'b1;
            tx_done_q   <= 1'b0;
            tx_busy_q   <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_idx_q    <= tx_idx_d;
            tx_shift_q  <= tx_shift_d;
            tx_serial_q <= tx_serial_d;
            tx_done_q   <= tx_done_d;
            tx_busy_q   <= tx_busy_d;
        end
    end

    assign tx_serial     = tx_serial_q;
    assign tx_done       = tx_done_q;
    assign tx_busy       = tx_busy_q;
    assign tx_state      = tx_state_q;
    assign tx_byte_index = tx_idx_q;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic          rx_sync1_q, rx_sync2_q;
    logic [2:0]    rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q,   rx_cnt_d;
    logic [2:0]    rx_idx_q,   rx_idx_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic [7:0]    rx_data_q,  rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          rx_ferr_q,  rx_ferr_d;

    // Two-flop synchroniser. It resets to the idle-high line level so that
    // reset release is not taken as a start edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
        end else begin
            rx_sync1_q <= rx_serial;
            rx_sync2_q <= rx_sync1_q;
        end
    end

    // After the start-bit mid-point check, every later sample is one full
    // bit period on. Each sample therefore also lands at mid-bit.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;

        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                rx_idx_d = '0;
                if (!rx_sync2_q) begin
                    rx_state_d = RX_START;
                end
            end

            RX_START: begin
                if (rx_cnt_q == BIT_MID) begin
                    rx_cnt_d   = '0;
                    // A line that is high again at mid-bit was a glitch.
                    rx_state_d = rx_sync2_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end

            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
                    if (rx_idx_q == 3'd7) begin
                        rx_idx_d   = '0;
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_idx_d = rx_idx_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end

            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d = '0;
                    if (rx_sync2_q) begin
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        rx_ferr_d = 1'b1;
                    end
                    rx_state_d = RX_CLEANUP;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end

            RX_CLEANUP: begin
                rx_state_d = RX_IDLE;
            end

            default: begin
                rx_cnt_d   = '0;
                rx_idx_d   = '0;
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    assign rx_data        = rx_data_q;
    assign rx_valid       = rx_valid_q;
    assign rx_frame_error = rx_ferr_q;

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: directed self-checking bench for uart_core with
// CLKS_PER_BIT=16. tx_serial is looped back to rx_serial except in the
// receiver-only scenarios, where the bench drives rx_serial itself.
module tb_uart_core;

    localparam int unsigned CPB = 16;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] tx_data;
    logic       tx_enable;
    logic       tx_serial;
    logic       tx_done;
    logic       tx_busy;
    logic [2:0] tx_state;
    logic [2:0] tx_byte_index;
    logic       rx_serial;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_error;

    logic loop_en;
    logic rx_drive;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    assign rx_serial = loop_en ? tx_serial : rx_drive;

    uart_core #(.CLKS_PER_BIT(CPB)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .tx_data        (tx_data),
        .tx_enable      (tx_enable),
        .tx_serial      (tx_serial),
        .tx_done        (tx_done),
        .tx_busy        (tx_busy),
        .tx_state       (tx_state),
        .tx_byte_index  (tx_byte_index),
        .rx_serial      (rx_serial),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_frame_error (rx_frame_error)
    );

    task automatic test_reset();
        reset_n   = 1'b0;
        tx_enable = 1'b0;
        tx_data   = 8'h00;
        loop_en   = 1'b1;
        rx_drive  = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        n_total++;
        if (tx_serial !== 1'b1) $display("FAIL reset_tx_serial: got %b expected 1", tx_serial);
        else n_pass++;
        n_total++;
        if (tx_done !== 1'b0) $display("FAIL reset_tx_done: got %b expected 0", tx_done);
        else n_pass++;
        n_total++;
        if (tx_busy !== 1'b0) $display("FAIL reset_tx_busy: got %b expected 0", tx_busy);
        else n_pass++;
        n_total++;
        if (tx_state !== 3'd0) $display("FAIL reset_tx_state: got %0d expected 0", tx_state);
        else n_pass++;
        n_total++;
        if (tx_byte_index !== 3'd0) $display("FAIL reset_tx_byte_index: got %0d expected 0", tx_byte_index);
        else n_pass++;
        n_total++;
        if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h expected 00", rx_data);
        else n_pass++;
        n_total++;
        if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b expected 0", rx_valid);
        else n_pass++;
        n_total++;
        if (rx_frame_error !== 1'b0) $display("FAIL reset_rx_frame_error: got %b expected 0", rx_frame_error);
        else n_pass++;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    // Frame for 0xAB, element b is bit period b (start, d0..d7, stop).
    task automatic test_loopback();
        logic [9:0] exp_frame;
        logic       exp_ser;
        logic [2:0] exp_state;
        logic [2:0] exp_idx;
        logic       exp_done;
        logic       exp_busy;
        int         valid_cnt;
        int         valid_k;
        int         ferr_cnt;
        exp_frame = 10'b1101010110;
        valid_cnt = 0;
        valid_k   = -1;
        ferr_cnt  = 0;
        loop_en   = 1'b1;
        @(negedge clock);
        tx_data   = 8'hAB;
        tx_enable = 1'b1;
        @(posedge clock);
        #1;
        tx_enable = 1'b0;
        // k counts clocks after the edge that sampled tx_enable.
        for (int k = 0; k < 200; k++) begin
            exp_ser   = (k < 160) ? exp_frame[k / 16] : 1'b1;
            exp_state = (k < 16) ? 3'd1 : (k < 144) ? 3'd2 : (k < 160) ? 3'd3 :
                        (k == 160) ? 3'd4 : 3'd0;
            exp_idx   = (k >= 16 && k < 144) ? 3'((k - 16) / 16) : 3'd0;
            exp_done  = (k == 160);
            exp_busy  = (k <= 160);
            if (k <= 165) begin
                n_total++;
                if (tx_serial !== exp_ser)
                    $display("FAIL lb_tx_serial k=%0d: got %b expected %b", k, tx_serial, exp_ser);
                else n_pass++;
                n_total++;
                if (tx_state !== exp_state)
                    $display("FAIL lb_tx_state k=%0d: got %0d expected %0d", k, tx_state, exp_state);
                else n_pass++;
                n_total++;
                if (tx_byte_index !== exp_idx)
                    $display("FAIL lb_tx_byte_index k=%0d: got %0d expected %0d", k, tx_byte_index, exp_idx);
                else n_pass++;
                n_total++;
                if (tx_done !== exp_done)
                    $display("FAIL lb_tx_done k=%0d: got %b expected %b", k, tx_done, exp_done);
                else n_pass++;
                n_total++;
                if (tx_busy !== exp_busy)
                    $display("FAIL lb_tx_busy k=%0d: got %b expected %b", k, tx_busy, exp_busy);
                else n_pass++;
            end
            if (k == 160) begin
                n_total++;
                if (rx_data !== 8'hAB) $display("FAIL lb_rx_data_at_done: got %h expected ab", rx_data);
                else n_pass++;
            end
            if (rx_valid === 1'b1) begin
                valid_cnt++;
                valid_k = k;
            end
            if (rx_frame_error === 1'b1) ferr_cnt++;
            @(posedge clock);
            #1;
        end
        n_total++;
        if (valid_cnt != 1) $display("FAIL lb_rx_valid_count: got %0d expected 1", valid_cnt);
        else n_pass++;
        n_total++;
        if (!(valid_k >= 150 && valid_k < 160))
            $display("FAIL lb_rx_valid_before_done: got k=%0d expected 150..159", valid_k);
        else n_pass++;
        n_total++;
        if (ferr_cnt != 0) $display("FAIL lb_frame_error_count: got %0d expected 0", ferr_cnt);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] got [$];
        logic [7:0] g0;
        logic [7:0] g1;
        int         ferr_cnt;
        int         done_cnt;
        ferr_cnt = 0;
        done_cnt = 0;
        loop_en  = 1'b1;
        @(negedge clock);
        tx_data   = 8'h00;
        tx_enable = 1'b1;
        @(posedge clock);
        #1;
        for (int k = 0; k < 340; k++) begin
            // Changing tx_data mid-frame must not disturb the first frame.
            if (k == 5) tx_data = 8'hFF;
            if (k == 160 || k == 161) begin
                n_total++;
                if (tx_serial !== 1'b1) $display("FAIL b2b_idle_gap k=%0d: got %b expected 1", k, tx_serial);
                else n_pass++;
            end
            if (k == 162) begin
                n_total++;
                if (tx_serial !== 1'b0) $display("FAIL b2b_second_start: got %b expected 0", tx_serial);
                else n_pass++;
                n_total++;
                if (tx_state !== 3'd1) $display("FAIL b2b_second_state: got %0d expected 1", tx_state);
                else n_pass++;
                tx_enable = 1'b0;
            end
            if (rx_valid === 1'b1) got.push_back(rx_data);
            if (rx_frame_error === 1'b1) ferr_cnt++;
            if (tx_done === 1'b1) done_cnt++;
            @(posedge clock);
            #1;
        end
        g0 = (got.size() > 0) ? got[0] : 8'hxx;
        g1 = (got.size() > 1) ? got[1] : 8'hxx;
        n_total++;
        if (got.size() != 2) $display("FAIL b2b_valid_count: got %0d expected 2", got.size());
        else n_pass++;
        n_total++;
        if (g0 !== 8'h00) $display("FAIL b2b_first_byte: got %h expected 00", g0);
        else n_pass++;
        n_total++;
        if (g1 !== 8'hFF) $display("FAIL b2b_second_byte: got %h expected ff", g1);
        else n_pass++;
        n_total++;
        if (ferr_cnt != 0) $display("FAIL b2b_frame_error_count: got %0d expected 0", ferr_cnt);
        else n_pass++;
        n_total++;
        if (done_cnt != 2) $display("FAIL b2b_done_count: got %0d expected 2", done_cnt);
        else n_pass++;
    endtask

    // 0x55 with the stop bit driven low; rx_data keeps 0xFF from before.
    task automatic test_frame_error();
        logic [9:0] frame;
        int         valid_cnt;
        int         ferr_cnt;
        frame     = {1'b0, 8'h55, 1'b0};
        valid_cnt = 0;
        ferr_cnt  = 0;
        rx_drive  = 1'b1;
        loop_en   = 1'b0;
        repeat (4) @(negedge clock);
        for (int k = 0; k < 220; k++) begin
            @(negedge clock);
            rx_drive = (k < 160) ? frame[k / 16] : 1'b1;
            @(posedge clock);
            #1;
            if (rx_valid === 1'b1) valid_cnt++;
            if (rx_frame_error === 1'b1) ferr_cnt++;
        end
        n_total++;
        if (ferr_cnt != 1) $display("FAIL ferr_pulse_count: got %0d expected 1", ferr_cnt);
        else n_pass++;
        n_total++;
        if (valid_cnt != 0) $display("FAIL ferr_rx_valid_count: got %0d expected 0", valid_cnt);
        else n_pass++;
        n_total++;
        if (rx_data !== 8'hFF) $display("FAIL ferr_rx_data_kept: got %h expected ff", rx_data);
        else n_pass++;
    endtask

    // A 3-clock low pulse must be rejected; a real 0xA5 frame afterwards
    // shows the receiver returned to IDLE.
    task automatic test_glitch();
        logic [9:0] frame;
        int         valid_cnt;
        int         ferr_cnt;
        frame     = {1'b1, 8'hA5, 1'b0};
        valid_cnt = 0;
        ferr_cnt  = 0;
        loop_en   = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clock);
            rx_drive = (k < 3) ? 1'b0 : 1'b1;
            @(posedge clock);
            #1;
            if (rx_valid === 1'b1) valid_cnt++;
            if (rx_frame_error === 1'b1) ferr_cnt++;
        end
        n_total++;
        if (valid_cnt != 0) $display("FAIL glitch_rx_valid_count: got %0d expected 0", valid_cnt);
        else n_pass++;
        n_total++;
        if (ferr_cnt != 0) $display("FAIL glitch_frame_error_count: got %0d expected 0", ferr_cnt);
        else n_pass++;
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            rx_drive = (k < 160) ? frame[k / 16] : 1'b1;
            @(posedge clock);
            #1;
            if (rx_valid === 1'b1) valid_cnt++;
            if (rx_frame_error === 1'b1) ferr_cnt++;
        end
        n_total++;
        if (valid_cnt != 1) $display("FAIL glitch_after_valid_count: got %0d expected 1", valid_cnt);
        else n_pass++;
        n_total++;
        if (rx_data !== 8'hA5) $display("FAIL glitch_after_rx_data: got %h expected a5", rx_data);
        else n_pass++;
        n_total++;
        if (ferr_cnt != 0) $display("FAIL glitch_after_frame_error: got %0d expected 0", ferr_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int valid_cnt;
        int done_k;
        valid_cnt = 0;
        done_k    = -1;
        rx_drive  = 1'b1;
        loop_en   = 1'b1;
        @(negedge clock);
        tx_data   = 8'h3C;
        tx_enable = 1'b1;
        @(posedge clock);
        #1;
        tx_enable = 1'b0;
        repeat (40) @(posedge clock);
        #3;
        n_total++;
        if (tx_state !== 3'd2) $display("FAIL rst_mid_in_data: got %0d expected 2", tx_state);
        else n_pass++;
        reset_n = 1'b0;
        #1;
        n_total++;
        if (tx_serial !== 1'b1) $display("FAIL rst_mid_tx_serial: got %b expected 1", tx_serial);
        else n_pass++;
        n_total++;
        if (tx_busy !== 1'b0) $display("FAIL rst_mid_tx_busy: got %b expected 0", tx_busy);
        else n_pass++;
        n_total++;
        if (tx_state !== 3'd0) $display("FAIL rst_mid_tx_state: got %0d expected 0", tx_state);
        else n_pass++;
        n_total++;
        if (tx_byte_index !== 3'd0) $display("FAIL rst_mid_tx_byte_index: got %0d expected 0", tx_byte_index);
        else n_pass++;
        n_total++;
        if (tx_done !== 1'b0) $display("FAIL rst_mid_tx_done: got %b expected 0", tx_done);
        else n_pass++;
        n_total++;
        if (rx_data !== 8'h00) $display("FAIL rst_mid_rx_data: got %h expected 00", rx_data);
        else n_pass++;
        n_total++;
        if (rx_valid !== 1'b0 || rx_frame_error !== 1'b0)
            $display("FAIL rst_mid_rx_flags: got %b%b expected 00", rx_valid, rx_frame_error);
        else n_pass++;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
        tx_data   = 8'h3C;
        tx_enable = 1'b1;
        @(posedge clock);
        #1;
        tx_enable = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (rx_valid === 1'b1) valid_cnt++;
            if (tx_done === 1'b1 && done_k < 0) begin
                done_k = k;
                n_total++;
                if (rx_data !== 8'h3C) $display("FAIL rst_after_rx_data: got %h expected 3c", rx_data);
                else n_pass++;
            end
            @(posedge clock);
            #1;
        end
        n_total++;
        if (done_k != 160) $display("FAIL rst_after_done_time: got k=%0d expected 160", done_k);
        else n_pass++;
        n_total++;
        if (valid_cnt != 1) $display("FAIL rst_after_valid_count: got %0d expected 1", valid_cnt);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_back_to_back();
        test_frame_error();
        test_glitch();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
